// File: rtl/memory_sequencer.sv
// Memory sequencer: fills memory with init data, bulk-loads it into an external
// register file, then writes results back. Define MEM_SEQ_HOLD_TIMEOUT_EN to add a HOLD timeout.
module memory_sequencer #(
    parameter int         DATA_W       = 48,
    parameter int         ADDR_W       = 3,
    parameter int         NUM_WORDS    = 8,
    parameter int         LAT          = 8,
    parameter logic [2:0] STORE_CODE   = 3'b100,
    parameter int         HOLD_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_memory,
    input  logic              load_memory,
    input  logic [2:0]        process,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] datapath_out,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              load_registers,
    output logic              done,
    output logic              finished_init,
    output logic              timeout
);

    typedef enum logic [2:0] {IDLE, INIT, LOAD, LOAD_STB, HOLD, WRITE} state_t;

    localparam logic [7:0]        LAST_WAIT = 8'(LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wcnt;
    logic       wait_done;
    logic       last_addr;
    logic       hold_expired;

    // Read data goes straight to the register file, not through this block.
    logic unused_rdata;
    assign unused_rdata = &{1'b0, mem_rdata};

    assign wait_done = (wcnt == LAST_WAIT);
    assign last_addr = (mem_addr == LAST_ADDR);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (init_memory)              next_state = INIT;
                      else if (load_memory)         next_state = LOAD;
            INIT:     if (wait_done && last_addr)   next_state = IDLE;
            LOAD:     if (wait_done)                next_state = LOAD_STB;
            LOAD_STB: next_state = last_addr ? HOLD : LOAD;
            HOLD:     if (init_memory)              next_state = INIT;
                      else if (process == STORE_CODE) next_state = WRITE;
                      else if (hold_expired)        next_state = IDLE;
            WRITE:    if (wait_done && last_addr)   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_we         = (state == INIT) || (state == WRITE);
        mem_wdata      = (state == INIT) ? init_data : datapath_out;
        load_registers = (state == LOAD_STB);
        done           = (state == IDLE);
    end

    // Counters restart only when a sequence starts from IDLE or HOLD; LOAD_STB -> LOAD advances instead.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr <= '0;
            wcnt     <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (next_state != state) begin
                        mem_addr <= '0;
                        wcnt     <= '0;
                    end
                end
                INIT, WRITE, LOAD: begin
                    if (wait_done) begin
                        wcnt <= '0;
                        if (state != LOAD && !last_addr) mem_addr <= mem_addr + ADDR_W'(1);
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                LOAD_STB: begin
                    wcnt <= '0;
                    if (!last_addr) mem_addr <= mem_addr + ADDR_W'(1);
                end
                default: begin
                    mem_addr <= '0;
                    wcnt     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                               finished_init <= 1'b0;
        else if (state == INIT && wait_done && last_addr) finished_init <= 1'b1;
    end

`ifdef MEM_SEQ_HOLD_TIMEOUT_EN
    logic [31:0] hold_cnt;

    assign hold_expired = (hold_cnt == 32'(HOLD_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset || state != HOLD || next_state != HOLD) hold_cnt <= '0;
        else                                               hold_cnt <= hold_cnt + 32'd1;
    end

    // Sticky until reset or the next LOAD starts.
    always_ff @(posedge clock) begin
        if (reset)                                     timeout <= 1'b0;
        else if (state == HOLD && next_state == IDLE)  timeout <= 1'b1;
        else if (state == IDLE && next_state == LOAD)  timeout <= 1'b0;
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = HOLD_TIMEOUT[0];
    assign hold_expired         = 1'b0;
    assign timeout              = 1'b0;
`endif

endmodule

// File: tb/tb_memory_sequencer.sv
// Directed bench for memory_sequencer at default parameters; define MEM_SEQ_HOLD_TIMEOUT_EN
// to exercise the HOLD timeout with HOLD_TIMEOUT=16.
module tb_memory_sequencer;

    localparam logic [47:0] INIT_WORD = 48'hA5A5_C3C3_0F0F;
`ifdef MEM_SEQ_HOLD_TIMEOUT_EN
    localparam int HOLD_TO = 16;
`else
    localparam int HOLD_TO = 1024;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        init_memory;
    logic        load_memory;
    logic [2:0]  process;
    logic [47:0] init_data;
    logic [47:0] datapath_out;
    logic [47:0] mem_rdata;
    logic [2:0]  mem_addr;
    logic [47:0] mem_wdata;
    logic        mem_we;
    logic        load_registers;
    logic        done;
    logic        finished_init;
    logic        timeout;

    int checkCount = 0;
    int failCount  = 0;

    memory_sequencer #(.HOLD_TIMEOUT(HOLD_TO)) dut (
        .clock(clock), .reset(reset), .init_memory(init_memory), .load_memory(load_memory),
        .process(process), .init_data(init_data), .datapath_out(datapath_out),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .load_registers(load_registers), .done(done), .finished_init(finished_init),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic init, input logic load, input logic [2:0] proc);
        init_memory = init;
        load_memory = load;
        process     = proc;
    endtask

    // Called in the first INIT cycle; returns in the first IDLE cycle afterwards.
    task automatic runInit();
        for (int i = 0; i < 64; i++) begin
            #1;
            checkOutput("init_we", mem_we, 1);
            checkOutput("init_addr", mem_addr, i / 8);
            checkOutput("init_wdata", mem_wdata, INIT_WORD);
            checkOutput("init_done", done, 0);
            waitCycle();
        end
        checkOutput("init_end_done", done, 1);
        checkOutput("init_end_finished", finished_init, 1);
        checkOutput("init_end_we", mem_we, 0);
    endtask

    // Called in IDLE; returns in the first HOLD cycle. An init request mid-LOAD must be ignored.
    task automatic runLoad();
        applyStimulus(0, 1, 3'b000);
        waitCycle();
        applyStimulus(0, 0, 3'b000);
        checkOutput("load_timeout_clr", timeout, 0);
        for (int w = 0; w < 8; w++) begin
            for (int c = 0; c < 8; c++) begin
                init_memory = (w == 3 && c == 0);
                checkOutput("load_strobe_lo", load_registers, 0);
                checkOutput("load_we", mem_we, 0);
                checkOutput("load_addr", mem_addr, w);
                waitCycle();
            end
            init_memory = 1'b0;
            checkOutput("load_strobe_hi", load_registers, 1);
            checkOutput("load_strobe_addr", mem_addr, w);
            checkOutput("load_done", done, 0);
            waitCycle();
        end
        checkOutput("hold_strobe", load_registers, 0);
        checkOutput("hold_done", done, 0);
        checkOutput("hold_we", mem_we, 0);
    endtask

    initial begin
        logic sawWe;
        reset        = 1'b1;
        applyStimulus(0, 0, 3'b000);
        init_data    = INIT_WORD;
        datapath_out = 48'h1111_2222_3333;
        mem_rdata    = 48'h0;
        waitCycle();
        waitCycle();
        checkOutput("rst_done", done, 1);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_strobe", load_registers, 0);
        checkOutput("rst_finished", finished_init, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_addr", mem_addr, 0);
        reset = 1'b0;
        waitCycle();
        checkOutput("idle_done", done, 1);
        process = 3'b100;
        waitCycle();
        checkOutput("idle_ignore_store", mem_we, 0);

        applyStimulus(1, 0, 3'b000);
        waitCycle();
        applyStimulus(0, 0, 3'b000);
        runInit();

        runLoad();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 3'b011);
            checkOutput("hold_stay_done", done, 0);
            checkOutput("hold_stay_we", mem_we, 0);
            checkOutput("hold_stay_strobe", load_registers, 0);
            waitCycle();
        end
        applyStimulus(0, 0, 3'b100);
        waitCycle();
        applyStimulus(0, 0, 3'b000);
        for (int i = 0; i < 64; i++) begin
            datapath_out = {16'hBEEF, 32'(i * 7 + 1)};
            #1;
            checkOutput("write_we", mem_we, 1);
            checkOutput("write_addr", mem_addr, i / 8);
            checkOutput("write_wdata", mem_wdata, {16'hBEEF, 32'(i * 7 + 1)});
            waitCycle();
        end
        checkOutput("write_end_done", done, 1);
        checkOutput("write_end_we", mem_we, 0);
        checkOutput("write_end_finished", finished_init, 1);

        applyStimulus(1, 1, 3'b000);
        waitCycle();
        applyStimulus(0, 0, 3'b000);
        runInit();

        runLoad();
        applyStimulus(1, 0, 3'b100);
        waitCycle();
        applyStimulus(0, 0, 3'b000);
        runInit();

        runLoad();
        sawWe = 1'b0;
`ifdef MEM_SEQ_HOLD_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            waitCycle();
            sawWe |= mem_we;
        end
        checkOutput("to_before_done", done, 0);
        checkOutput("to_before_flag", timeout, 0);
        waitCycle();
        checkOutput("to_done", done, 1);
        checkOutput("to_flag", timeout, 1);
        checkOutput("to_no_we", sawWe, 0);
        waitCycle();
        checkOutput("to_sticky", timeout, 1);
        runLoad();
`else
        for (int k = 0; k < 2000; k++) begin
            waitCycle();
            sawWe |= mem_we;
        end
        checkOutput("hold_2000_done", done, 0);
        checkOutput("hold_2000_timeout", timeout, 0);
        checkOutput("hold_2000_no_we", sawWe, 0);
`endif

        applyStimulus(0, 0, 3'b100);
        waitCycle();
        applyStimulus(0, 0, 3'b000);
        for (int k = 0; k < 24; k++) waitCycle();
        checkOutput("write3_addr", mem_addr, 3);
        checkOutput("write3_we", mem_we, 1);
        reset = 1'b1;
        waitCycle();
        checkOutput("midrst_done", done, 1);
        checkOutput("midrst_we", mem_we, 0);
        checkOutput("midrst_finished", finished_init, 0);
        checkOutput("midrst_addr", mem_addr, 0);
        checkOutput("midrst_strobe", load_registers, 0);
        reset = 1'b0;
        waitCycle();
        checkOutput("postrst_idle", done, 1);
        checkOutput("postrst_we", mem_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 Parameter DATA_W, default 48: width of one memory word.
REQ-002 Parameter ADDR_W, default 3: memory address width.
REQ-003 Parameter NUM_WORDS, default 8: words per sequence; legal range 1..2^ADDR_W.
REQ-004 Parameter LAT, default 8: cycles each access is held; legal range 1..255.
REQ-005 Parameter STORE_CODE, default 3'b100: process value that triggers write-back.
REQ-006 Parameter HOLD_TIMEOUT, default 1024: HOLD timeout in cycles; used only when the timeout feature is compiled in.
REQ-007 clock  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 init_memory  in  1  request to write init_data into all NUM_WORDS words.
REQ-010 load_memory  in  1  request to read all words into the register file.
REQ-011 process  in  3  datapath phase code.
REQ-012 init_data  in  DATA_W  initial word for address mem_addr.
REQ-013 datapath_out  in  DATA_W  write-back word for index mem_addr.
REQ-014 mem_rdata  in  DATA_W  memory read data.
REQ-015 mem_addr  out  ADDR_W  memory address, also the register-file index.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 load_registers  out  1  one-cycle strobe: register[mem_addr] <= mem_rdata.
REQ-019 done  out  1  high only in IDLE.
REQ-020 finished_init  out  1  sticky flag, set once an INIT sequence completes.
REQ-021 timeout  out  1  sticky HOLD-timeout flag.

Function
REQ-022 States: IDLE, INIT, LOAD, LOAD_STB, HOLD, WRITE; a registered word counter (mem_addr) and a registered wait counter (wcnt, 0..LAT-1).
REQ-023 IDLE: init_memory -> INIT; else load_memory -> LOAD; else stay. If both are high, init_memory wins.
REQ-024 Entering INIT, LOAD or WRITE clears mem_addr and wcnt to 0.
REQ-025 INIT: mem_we=1, mem_wdata=init_data; each address is held LAT cycles; at wcnt==LAT-1 the address advances, and on address NUM_WORDS-1 the block goes to IDLE and sets finished_init.
REQ-026 LOAD: mem_we=0; the address is held LAT cycles, then the block goes to LOAD_STB.
REQ-027 LOAD_STB: one cycle with load_registers=1; then the next address in LOAD, or HOLD after address NUM_WORDS-1.
REQ-028 HOLD: process==STORE_CODE -> WRITE; init_memory -> INIT. If both are true, init_memory wins. Otherwise stay.
REQ-029 WRITE: mem_we=1, mem_wdata=datapath_out; LAT cycles per address; after address NUM_WORDS-1 the block goes to IDLE.
REQ-030 In non-write states, mem_wdata=datapath_out and mem_we=0.
REQ-031 Latency: INIT = NUM_WORDS*LAT cycles; LOAD = NUM_WORDS*(LAT+1) cycles from entering LOAD to entering HOLD; WRITE = NUM_WORDS*LAT cycles.
REQ-032 Requests arriving outside the states that accept them are ignored; requests are level-sampled, never queued.
REQ-033 When NUM_WORDS==1 or LAT==1, the same rules apply with no skipped or extra cycles.
REQ-034 Counters never exceed LAT-1 or NUM_WORDS-1; there is no wrap-around into unused addresses.

Reset
REQ-035 reset high at any clock edge, including mid-sequence, forces IDLE, mem_addr=0, wcnt=0, mem_we=0, load_registers=0, finished_init=0 and timeout=0; the interrupted access is abandoned.
REQ-036 In the first cycle after reset, done=1.

Configuration
REQ-037 Macro MEM_SEQ_HOLD_TIMEOUT_EN, when defined: a HOLD residency counter runs. After HOLD_TIMEOUT consecutive HOLD cycles without a transition, the block goes to IDLE, sets timeout, and does not write back.
REQ-038 timeout clears only on reset, or on entry to LOAD.
REQ-039 Macro MEM_SEQ_HOLD_TIMEOUT_EN, when undefined: no counter exists, HOLD waits indefinitely, and timeout is tied to 0.

Verification
REQ-040 Reset, then init_memory=1 for one cycle with defaults -> mem_we high 64 cycles, addresses 0..7 each 8 cycles, then done=1 and finished_init=1.
REQ-041 From IDLE, load_memory pulse -> 8 load_registers strobes at mem_addr 0..7, each following 8 cycles of hold; HOLD entered 72 cycles after LOAD entry.
REQ-042 In HOLD, process=3'b100 -> 64 write cycles with mem_wdata=datapath_out, then IDLE; process=3'b011 -> remain in HOLD.
REQ-043 In IDLE, init_memory=1 and load_memory=1 together -> INIT is taken; in HOLD, init_memory=1 and process=3'b100 together -> INIT is taken.
REQ-044 reset asserted at WRITE address 3 -> next cycle IDLE, mem_we=0, finished_init=0.
REQ-045 With MEM_SEQ_HOLD_TIMEOUT_EN and HOLD_TIMEOUT=16, idle 16 cycles in HOLD -> IDLE, timeout=1, no mem_we; without the macro, the block is still in HOLD after 2000 cycles.
